rtype_exec_unit: RTL and testbench

Multi-cycle R-type execute unit for the single-issue MIPS datapath. It owns the 32×32 general register file. It accepts one R-type instruction per handshake, reads rs/rt, and computes the funct result through the ALU slice functions (add/sub/logic/slt/sltu/shifts). It then writes rd and reports the write-back on a one-cycle strobe. It is the stage directly upstream of the sltu comparator and feeds it its rs/rt operands.

---
 rtl/rtype_exec_unit_if.sv | 36 +++
 rtl/rtype_exec_unit.sv | 193 +++++++++++++++++++
 tb/tb_rtype_exec_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rtype_exec_unit_if.sv
// rtl/rtype_exec_unit_if.sv - instruction, preload, write-back and debug bus of rtype_exec_unit
//
// Purpose: groups every signal of rtype_exec_unit except clk/rst.
//   master : issuing side (drives instr/preload/debug address)
//   slave  : the execute unit
// Signals:
//   instr_valid / instr_ready / instr[31:0]  instruction handshake
//   ld_en / ld_addr[4:0] / ld_data[31:0]     register preload (IDLE only)
//   wb_valid / wb_rd[4:0] / wb_data[31:0]    write-back report
//   err / err_code[1:0]                      discard strobe and reason
//   dbg_addr[4:0] / dbg_data[31:0]           combinational register-file read
interface rtype_exec_unit_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;
  logic [1:0]  err_code;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  modport master (
    output instr_valid, instr, ld_en, ld_addr, ld_data, dbg_addr,
    input  instr_ready, wb_valid, wb_rd, wb_data, err, err_code, dbg_data
  );

  modport slave (
    input  instr_valid, instr, ld_en, ld_addr, ld_data, dbg_addr,
    output instr_ready, wb_valid, wb_rd, wb_data, err, err_code, dbg_data
  );
endinterface

// File: rtl/rtype_exec_unit.sv
// rtl/rtype_exec_unit.sv - multi-cycle MIPS R-type execute unit with 32x32 register file
//
// Purpose: accepts one R-type instruction per handshake, reads rs/rt from
// the register file, computes the funct result, reports it on a one-cycle
// write-back strobe and writes rd. Sequence IDLE -> READ -> EXEC -> WB.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (clears state and register file)
//   bus  : rtype_exec_unit_if.slave (instr handshake, preload, write-back, debug read)
// Build option:
//   SHIFT_EN : when defined, sll (0x00) / srl (0x02) are executed; otherwise
//              they decode as illegal (err_code 01).
module rtype_exec_unit (
  input  logic               clk,
  input  logic               rst,
  rtype_exec_unit_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_OVF     = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q;
  logic [31:0] rs_val_q, rt_val_q;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic [31:0] rf_q [32];

  logic        handshake;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [31:0] rs_rd, rt_rd;
  logic [31:0] sum, diff;
  logic        add_ovf, sub_ovf;

  assign op    = instr_q[31:26];
  assign rs    = instr_q[25:21];
  assign rt    = instr_q[20:16];
  assign rd    = instr_q[15:11];
  assign shamt = instr_q[10:6];
  assign funct = instr_q[5:0];

  assign handshake = bus.instr_valid && (state_q == S_IDLE);

  // Register 0 is never written, but the explicit zero keeps the read
  // correct independent of what the storage slot holds.
  assign rs_rd = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rt_rd = (rt == 5'd0) ? 32'd0 : rf_q[rt];

  assign sum  = rs_val_q + rt_val_q;
  assign diff = rs_val_q - rt_val_q;
  // Signed overflow: add of like-signed operands flips sign; sub of
  // unlike-signed operands produces a sign different from the minuend.
  assign add_ovf = (rs_val_q[31] == rt_val_q[31]) && (sum[31]  != rs_val_q[31]);
  assign sub_ovf = (rs_val_q[31] != rt_val_q[31]) && (diff[31] != rs_val_q[31]);

`ifndef SHIFT_EN
  logic unused_shamt;
  assign unused_shamt = ^shamt;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (handshake) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    result_d   = 32'd0;
    err_d      = 1'b0;
    err_code_d = ERR_NONE;
    if (op != 6'd0) begin
      err_d      = 1'b1;
      err_code_d = ERR_ILLEGAL;
    end else begin
      case (funct)
        F_ADD: begin
          result_d = sum;
          if (add_ovf) begin
            err_d      = 1'b1;
            err_code_d = ERR_OVF;
          end
        end
        F_ADDU: result_d = sum;
        F_SUB: begin
          result_d = diff;
          if (sub_ovf) begin
            err_d      = 1'b1;
            err_code_d = ERR_OVF;
          end
        end
        F_SUBU: result_d = diff;
        F_AND:  result_d = rs_val_q & rt_val_q;
        F_OR:   result_d = rs_val_q | rt_val_q;
        F_XOR:  result_d = rs_val_q ^ rt_val_q;
        F_NOR:  result_d = ~(rs_val_q | rt_val_q);
        F_SLT:  result_d = {31'd0, ($signed(rs_val_q) < $signed(rt_val_q))};
        F_SLTU: result_d = {31'd0, (rs_val_q < rt_val_q)};
`ifdef SHIFT_EN
        F_SLL:  result_d = rt_val_q << shamt;
        F_SRL:  result_d = rt_val_q >> shamt;
`endif
        default: begin
          err_d      = 1'b1;
          err_code_d = ERR_ILLEGAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      instr_q    <= 32'd0;
      rs_val_q   <= 32'd0;
      rt_val_q   <= 32'd0;
      result_q   <= 32'd0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (handshake) instr_q <= bus.instr;
        S_READ: begin
          rs_val_q <= rs_rd;
          rt_val_q <= rt_rd;
        end
        S_EXEC: begin
          result_q   <= result_d;
          err_q      <= err_d;
          err_code_q <= err_code_d;
          // wb_* are loaded here so they are valid throughout WB and then
          // hold until the next instruction reaches WB.
          wb_rd_q    <= rd;
          wb_data_q  <= err_d ? 32'd0 : result_d;
        end
        default: ;
      endcase
    end
  end

  // Register file. Preload and write-back occur in different states
  // (IDLE vs WB->IDLE edge), so they never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      if (state_q == S_IDLE) begin
        if (bus.ld_en && (bus.ld_addr != 5'd0)) rf_q[bus.ld_addr] <= bus.ld_data;
      end else if (state_q == S_WB) begin
        if (!err_q && (rd != 5'd0)) rf_q[rd] <= result_q;
      end
    end
  end

  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.wb_valid    = (state_q == S_WB);
  assign bus.err         = (state_q == S_WB) && err_q;
  assign bus.err_code    = err_code_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.dbg_data    = (bus.dbg_addr == 5'd0) ? 32'd0 : rf_q[bus.dbg_addr];

endmodule

// File: tb/tb_rtype_exec_unit.sv
// tb/tb_rtype_exec_unit.sv - directed self-checking bench for rtype_exec_unit
module tb_rtype_exec_unit;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  rtype_exec_unit_if bus ();

  rtype_exec_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rf_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.dbg_addr = addr;
    #1;
    check(tag, bus.dbg_data, exp);
  endtask

  task automatic preload(input logic [4:0] addr, input logic [31:0] data);
    bus.ld_en   = 1'b1;
    bus.ld_addr = addr;
    bus.ld_data = data;
    @(negedge clk);
    bus.ld_en   = 1'b0;
  endtask

  // Called at a negedge while IDLE; returns at the negedge of the next IDLE
  // cycle so another instruction can be offered back to back.
  task automatic issue(input string tag, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                       input logic [5:0] fn, input logic [31:0] exp_data, input logic [1:0] exp_code);
    check({tag, ".ready_idle"}, {31'd0, bus.instr_ready}, 32'd1);
    bus.instr       = {op, rs, rt, rd, sh, fn};
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = $urandom;
    for (int k = 1; k <= 2; k++) begin
      check({tag, ".ready_busy"}, {31'd0, bus.instr_ready}, 32'd0);
      check({tag, ".wb_early"}, {31'd0, bus.wb_valid}, 32'd0);
      @(negedge clk);
    end
    check({tag, ".wb_valid"}, {31'd0, bus.wb_valid}, 32'd1);
    check({tag, ".ready_wb"}, {31'd0, bus.instr_ready}, 32'd0);
    check({tag, ".err"}, {31'd0, bus.err}, {31'd0, (exp_code != 2'b00)});
    check({tag, ".err_code"}, {30'd0, bus.err_code}, {30'd0, exp_code});
    check({tag, ".wb_rd"}, {27'd0, bus.wb_rd}, {27'd0, rd});
    check({tag, ".wb_data"}, bus.wb_data, exp_data);
    @(negedge clk);
    check({tag, ".ready_back"}, {31'd0, bus.instr_ready}, 32'd1);
    check({tag, ".wb_off"}, {31'd0, bus.wb_valid}, 32'd0);
    check({tag, ".err_off"}, {31'd0, bus.err}, 32'd0);
    check({tag, ".wb_hold"}, bus.wb_data, exp_data);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;
    bus.ld_en       = 1'b0;
    bus.ld_addr     = 5'd0;
    bus.ld_data     = 32'd0;
    bus.dbg_addr    = 5'd0;
    rst = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst.ready", {31'd0, bus.instr_ready}, 32'd1);
    check("rst.wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst.err", {31'd0, bus.err}, 32'd0);
    check("rst.err_code", {30'd0, bus.err_code}, 32'd0);
    check("rst.wb_rd", {27'd0, bus.wb_rd}, 32'd0);
    check("rst.wb_data", bus.wb_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 32; a++) rf_check("rst.rf", a[4:0], 32'd0);
    @(negedge clk);

    // sltu with all-ones versus small positive
    preload(5'd1, 32'hFFFF_FFFF);
    preload(5'd2, 32'h0F80_0000);
    issue("sltu3", 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2B, 32'd0, 2'b00);
    rf_check("rf3", 5'd3, 32'd0);
    issue("sltu4", 6'd0, 5'd2, 5'd1, 5'd4, 5'd0, 6'h2B, 32'd1, 2'b00);
    rf_check("rf4", 5'd4, 32'd1);

    // signed versus unsigned compare on a negative operand
    preload(5'd5, 32'h8004_0003);
    preload(5'd6, 32'h0000_000F);
    issue("sltu7", 6'd0, 5'd5, 5'd6, 5'd7, 5'd0, 6'h2B, 32'd0, 2'b00);
    rf_check("rf7", 5'd7, 32'd0);
    issue("slt8", 6'd0, 5'd5, 5'd6, 5'd8, 5'd0, 6'h2A, 32'd1, 2'b00);
    rf_check("rf8", 5'd8, 32'd1);
    issue("xor18", 6'd0, 5'd5, 5'd6, 5'd18, 5'd0, 6'h26, 32'h8004_000C, 2'b00);
    rf_check("rf18", 5'd18, 32'h8004_000C);

    // overflow discards; addu wraps
    preload(5'd9, 32'h7FFF_FFFF);
    preload(5'd10, 32'h0000_0001);
    issue("add11", 6'd0, 5'd9, 5'd10, 5'd11, 5'd0, 6'h20, 32'd0, 2'b10);
    rf_check("rf11_kept", 5'd11, 32'd0);
    issue("addu11", 6'd0, 5'd9, 5'd10, 5'd11, 5'd0, 6'h21, 32'h8000_0000, 2'b00);
    rf_check("rf11", 5'd11, 32'h8000_0000);
    issue("sub17", 6'd0, 5'd10, 5'd9, 5'd17, 5'd0, 6'h22, 32'h8000_0002, 2'b00);
    rf_check("rf17", 5'd17, 32'h8000_0002);
    issue("sub_ovf", 6'd0, 5'd11, 5'd10, 5'd19, 5'd0, 6'h22, 32'd0, 2'b10);
    rf_check("rf19", 5'd19, 32'd0);

    // illegal opcode and rd=0
    issue("op08", 6'h08, 5'd9, 5'd10, 5'd16, 5'd0, 6'h21, 32'd0, 2'b01);
    rf_check("rf16", 5'd16, 32'd0);
    issue("rd0", 6'd0, 5'd9, 5'd10, 5'd0, 5'd0, 6'h21, 32'h8000_0000, 2'b00);
    rf_check("rf0", 5'd0, 32'd0);
    issue("funct3f", 6'd0, 5'd9, 5'd10, 5'd16, 5'd0, 6'h3F, 32'd0, 2'b01);

    // dependent pair, back to back
    issue("dep12", 6'd0, 5'd10, 5'd10, 5'd12, 5'd0, 6'h21, 32'd2, 2'b00);
    issue("dep13", 6'd0, 5'd12, 5'd12, 5'd13, 5'd0, 6'h21, 32'd4, 2'b00);
    rf_check("rf13", 5'd13, 32'd4);

    // preload in the handshake cycle is seen by the instruction
    bus.ld_en   = 1'b1;
    bus.ld_addr = 5'd20;
    bus.ld_data = 32'd5;
    issue("ld_hs", 6'd0, 5'd20, 5'd0, 5'd21, 5'd0, 6'h21, 32'd5, 2'b00);
    bus.ld_en   = 1'b0;
    rf_check("rf21", 5'd21, 32'd5);

    // reset during EXEC aborts the instruction
    bus.instr       = {6'd0, 5'd0, 5'd0, 5'd14, 5'd0, 6'h27};
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort.ready", {31'd0, bus.instr_ready}, 32'd1);
    check("abort.wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort.no_wb", {31'd0, bus.wb_valid}, 32'd0);
    end
    rf_check("abort.rf14", 5'd14, 32'd0);
    rf_check("abort.rf9", 5'd9, 32'd0);

    // shifter
    preload(5'd10, 32'h0000_0001);
    preload(5'd9, 32'h7FFF_FFFF);
`ifdef SHIFT_EN
    issue("sll15", 6'd0, 5'd0, 5'd10, 5'd15, 5'd31, 6'h00, 32'h8000_0000, 2'b00);
    rf_check("rf15", 5'd15, 32'h8000_0000);
    issue("srl22", 6'd0, 5'd0, 5'd9, 5'd22, 5'd4, 6'h02, 32'h07FF_FFFF, 2'b00);
    rf_check("rf22", 5'd22, 32'h07FF_FFFF);
`else
    issue("sll15", 6'd0, 5'd0, 5'd10, 5'd15, 5'd31, 6'h00, 32'd0, 2'b01);
    rf_check("rf15", 5'd15, 32'd0);
    issue("srl22", 6'd0, 5'd0, 5'd9, 5'd22, 5'd4, 6'h02, 32'd0, 2'b01);
    rf_check("rf22", 5'd22, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
